// File: rtl/glyph_row_scaler3_pkg.sv
// Shared VGA glyph constants: the divide-by-3 address side and the 3x pixel
// expander both derive their geometry from these values.
package glyph_row_scaler3_pkg;

    localparam int GLYPH_ROW_W = 8;
    localparam int GLYPH_SCALE = 3;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } row_state_t;

endpackage

// File: rtl/glyph_row_scaler3_if.sv
// Glyph row handshake. A row transfers on every rising clk edge where
// in_valid && in_ready. in_row must be stable while in_valid is high.
interface glyph_row_scaler3_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_row;

    modport master (output in_valid, output in_row, input in_ready);
    modport slave  (input in_valid, input in_row, output in_ready);
endinterface

// File: rtl/glyph_rep_ctr.sv
// Repeat / bit-position counters for the glyph expander. bit_adv fires on the
// last repeat of a bit, row_end on the last repeat of the last bit.
module glyph_rep_ctr #(
    parameter int GLYPH_W = 8,
    parameter int SCALE   = 3,
    parameter int RW      = (SCALE > 1) ? $clog2(SCALE) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          step,
    output logic [RW-1:0] rep,
    output logic          bit_adv,
    output logic          row_end
);
    localparam int BW = $clog2(GLYPH_W);

    logic [BW-1:0] bit_idx;

    assign bit_adv = step && (rep == RW'(SCALE - 1));
    assign row_end = bit_adv && (bit_idx == BW'(GLYPH_W - 1));

    // Both counters wrap to zero at row end, so a seamless reload needs no clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep     <= '0;
            bit_idx <= '0;
        end else if (clr) begin
            rep     <= '0;
            bit_idx <= '0;
        end else if (step) begin
            if (bit_adv) begin
                rep     <= '0;
                bit_idx <= row_end ? '0 : bit_idx + BW'(1);
            end else begin
                rep <= rep + RW'(1);
            end
        end
    end

endmodule

// File: rtl/glyph_row_scaler3.sv
// Horizontal glyph pixel expander: serialises a glyph row MSB first, repeating
// each bit SCALE times, with a hold register so consecutive cells have no gap.
module glyph_row_scaler3
    import glyph_row_scaler3_pkg::*;
#(
    parameter int GLYPH_W = GLYPH_ROW_W,
    parameter int SCALE   = GLYPH_SCALE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pix_en,
    input  logic                  flush,
    glyph_row_scaler3_if.slave    rows,
    output logic                  pix_out,
    output logic                  pix_valid,
    output logic                  underrun,
    output logic [2:0]            sub_phase,
    output row_state_t            dbg_state
);
    localparam int RW = (SCALE > 1) ? $clog2(SCALE) : 1;

    row_state_t           state, state_n;
    logic [GLYPH_W-1:0]   sr;
    logic [GLYPH_W-1:0]   hold;
    logic                 hold_valid;
    logic [RW-1:0]        rep;
    logic                 active, accept, step, bit_adv, row_end;

    assign active        = (state == ST_ACTIVE);
    assign rows.in_ready = !hold_valid && !flush;
    assign accept        = rows.in_valid && rows.in_ready;
    assign step          = pix_en && active;
    assign dbg_state     = state;

    glyph_rep_ctr #(.GLYPH_W(GLYPH_W), .SCALE(SCALE), .RW(RW)) u_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (flush || (accept && !active)),
        .step    (step),
        .rep     (rep),
        .bit_adv (bit_adv),
        .row_end (row_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (flush) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (accept) state_n = ST_ACTIVE;
                ST_ACTIVE: if (row_end && !hold_valid && !accept) state_n = ST_IDLE;
                default:   state_n = ST_IDLE;
            endcase
        end
    end

    // A row accepted exactly at row end bypasses hold and goes straight to sr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr         <= '0;
            hold       <= '0;
            hold_valid <= 1'b0;
        end else if (flush) begin
            hold_valid <= 1'b0;
        end else begin
            if (accept && !active) begin
                sr <= rows.in_row;
            end else if (row_end) begin
                if (hold_valid) begin
                    sr         <= hold;
                    hold_valid <= 1'b0;
                end else if (accept) begin
                    sr <= rows.in_row;
                end
            end else begin
                if (bit_adv) sr <= {sr[GLYPH_W-2:0], 1'b0};
                if (accept) begin
                    hold       <= rows.in_row;
                    hold_valid <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_out   <= 1'b0;
            pix_valid <= 1'b0;
            underrun  <= 1'b0;
            sub_phase <= 3'd0;
        end else if (flush) begin
            pix_out   <= 1'b0;
            pix_valid <= 1'b0;
            underrun  <= 1'b0;
        end else if (pix_en) begin
            pix_out   <= active ? sr[GLYPH_W-1] : 1'b0;
            pix_valid <= active;
            underrun  <= !active;
            sub_phase <= active ? 3'(rep) : 3'd0;
        end else begin
            underrun  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_glyph_row_scaler3.sv
// Bench for glyph_row_scaler3: directed cases plus random traffic against a
// pixel-queue reference model, and a SCALE=1 / 4-bit serializer build.
module tb_glyph_row_scaler3;
    import glyph_row_scaler3_pkg::*;

    localparam int W = GLYPH_ROW_W;
    localparam int S = GLYPH_SCALE;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       pix_en, flush, pix_out, pix_valid, underrun;
    logic [2:0] sub_phase;
    row_state_t dbg_state;
    glyph_row_scaler3_if #(.W(W)) rif ();

    logic       pix_en2, flush2, pix_out2, pix_valid2, underrun2;
    logic [2:0] sub_phase2;
    row_state_t dbg_state2;
    glyph_row_scaler3_if #(.W(4)) rif2 ();

    glyph_row_scaler3 #(.GLYPH_W(W), .SCALE(S)) dut (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .flush(flush), .rows(rif),
        .pix_out(pix_out), .pix_valid(pix_valid), .underrun(underrun),
        .sub_phase(sub_phase), .dbg_state(dbg_state)
    );

    glyph_row_scaler3 #(.GLYPH_W(4), .SCALE(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en2), .flush(flush2), .rows(rif2),
        .pix_out(pix_out2), .pix_valid(pix_valid2), .underrun(underrun2),
        .sub_phase(sub_phase2), .dbg_state(dbg_state2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the active row is a queue of {phase, bit} pixels.
    logic [3:0]   pq[$];
    logic [W-1:0] m_hold;
    bit           m_hold_v;
    logic         m_pix, m_valid, m_under;
    logic [2:0]   m_sub;
    logic         exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        pq.delete();
        m_hold_v = 0;
        m_hold   = '0;
        m_pix    = 0;
        m_valid  = 0;
        m_under  = 0;
        m_sub    = 0;
    endtask

    task automatic push_row(input logic [W-1:0] row);
        for (int b = W - 1; b >= 0; b--)
            for (int p = 0; p < S; p++)
                pq.push_back({3'(p), row[b]});
    endtask

    task automatic model_step(input logic pe, input logic fl, input logic iv, input logic [W-1:0] row);
        bit         idle, acc;
        logic [3:0] e;
        idle = (pq.size() == 0);
        acc  = iv && !m_hold_v && !fl;
        if (fl) begin
            pq.delete();
            m_hold_v = 0;
            m_pix    = 0;
            m_valid  = 0;
            m_under  = 0;
            return;
        end
        m_under = 0;
        if (pe) begin
            if (!idle) begin
                e       = pq.pop_front();
                m_pix   = e[0];
                m_valid = 1;
                m_sub   = e[3:1];
            end else begin
                m_pix   = 0;
                m_valid = 0;
                m_sub   = 0;
                m_under = 1;
            end
        end
        if (idle) begin
            if (acc) push_row(row);
        end else if (pq.size() == 0) begin
            if (m_hold_v) begin
                push_row(m_hold);
                m_hold_v = 0;
            end else if (acc) begin
                push_row(row);
            end
        end else if (acc) begin
            m_hold   = row;
            m_hold_v = 1;
        end
    endtask

    task automatic check_outputs();
        check("pix_out",   pix_out,   m_pix);
        check("pix_valid", pix_valid, m_valid);
        check("underrun",  underrun,  m_under);
        check("sub_phase", sub_phase, m_sub);
    endtask

    task automatic cycle(input logic pe, input logic fl, input logic iv, input logic [W-1:0] row);
        @(negedge clk);
        pix_en       = pe;
        flush        = fl;
        rif.in_valid = iv;
        rif.in_row   = row;
        #1;
        check("in_ready", rif.in_ready, !m_hold_v && !fl);
        @(posedge clk);
        model_step(pe, fl, iv, row);
        #1;
        check_outputs();
    endtask

    task automatic cycle2(input logic pe, input logic iv, input logic [3:0] row);
        @(negedge clk);
        pix_en2       = pe;
        rif2.in_valid = iv;
        rif2.in_row   = row;
        @(posedge clk);
        #1;
    endtask

    initial begin
        pix_en = 0; flush = 0; rif.in_valid = 0; rif.in_row = '0;
        pix_en2 = 0; flush2 = 0; rif2.in_valid = 0; rif2.in_row = '0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        check("rst_in_ready", rif.in_ready, 1);
        check("rst_valid2", pix_valid2, 0);
        @(negedge clk);
        rst_n = 1;

        // Single row 1010_0001, continuous pix_en, trailing underruns
        cycle(1, 0, 1, 8'b1010_0001);
        for (int i = 0; i < W * S + 3; i++) cycle(1, 0, 0, '0);

        // FF then 00 offered during the first row: seamless
        cycle(0, 0, 1, 8'hFF);
        cycle(1, 0, 1, 8'h00);
        for (int i = 0; i < 2 * W * S + 2; i++) cycle(1, 0, 0, '0);

        // Gapped pix_en with row 80
        cycle(0, 0, 1, 8'h80);
        for (int i = 0; i < 2 * W * S; i++) cycle(i[0] == 1'b0, 0, 0, '0);

        // Flush at pixel 10 of F0 while a row is offered, then row 01
        cycle(0, 0, 1, 8'hF0);
        for (int i = 0; i < 10; i++) cycle(1, 0, 0, '0);
        cycle(1, 1, 1, 8'h01);
        check("flush_state", dbg_state, ST_IDLE);
        cycle(1, 0, 1, 8'h01);
        for (int i = 0; i < W * S + 1; i++) cycle(1, 0, 0, '0);

        // Async reset mid-row with hold full
        cycle(0, 0, 1, 8'hC3);
        cycle(1, 0, 1, 8'h5A);
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, '0);
        #2;
        rst_n = 0;
        #1;
        model_reset();
        check_outputs();
        check("rst_mid_in_ready", rif.in_ready, 1);
        @(negedge clk);
        rst_n = 1;
        cycle(1, 0, 0, '0);

        // Random traffic against the model
        for (int i = 0; i < 800; i++)
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 59) == 0,
                  $urandom_range(0, 1) == 1, W'($urandom));
        cycle(0, 1, 0, '0);

        // SCALE=1, 4-bit build: 1001 then 0110 back to back
        exp_q = '{1, 0, 0, 1, 0, 1, 1, 0};
        cycle2(1, 1, 4'b1001);
        check("s1_underrun_first", underrun2, 1);
        cycle2(1, 1, 4'b0110);
        check("s1_pix", pix_out2, exp_q.pop_front());
        check("s1_valid", pix_valid2, 1);
        while (exp_q.size() > 0) begin
            cycle2(1, 0, 4'b0000);
            check("s1_pix", pix_out2, exp_q.pop_front());
            check("s1_valid", pix_valid2, 1);
            check("s1_sub", sub_phase2, 0);
        end
        cycle2(1, 0, 4'b0000);
        check("s1_underrun_last", underrun2, 1);
        check("s1_valid_last", pix_valid2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/glyph_row_scaler3.md
Name: glyph_row_scaler3

Overview:
Horizontal 3x glyph pixel expander for the VGA glyph path. It is the inverse of the screen-x-to-glyph-x divide-by-3 mapping.
- Accepts one glyph row (GLYPH_W bits, MSB = leftmost pixel) per valid/ready handshake.
- On each pixel strobe it emits the current bit, repeating each bit SCALE times.
- Double-buffered: the next row is fetched from glyph ROM while the current row is still being shifted out, so back-to-back cells have no gap pixels.

Parameters:
GLYPH_W, 8, bits per glyph row (2..16)
SCALE, 3, horizontal repeat count per glyph bit (1..7)

Ports:
clk  in  1  pixel-domain clock
rst_n  in  1  asynchronous active-low reset
pix_en  in  1  pixel strobe; one output pixel per cycle with pix_en=1
flush  in  1  synchronous clear of all row state (end of line / hblank)
in_valid  in  1  glyph row offered
in_row  in  GLYPH_W  glyph row bits, MSB first
in_ready  out  1  row accepted when in_valid && in_ready
pix_out  out  1  registered pixel value
pix_valid  out  1  registered; 1 when pix_out came from a loaded row
underrun  out  1  registered one-cycle pulse: pix_en while no row active
sub_phase  out  3  registered repeat index (0..SCALE-1) of the pixel on pix_out

Behaviour:
- Reset (async, rst_n=0): pix_out=0, pix_valid=0, underrun=0, sub_phase=0, active=0, hold_valid=0, rep=0, bit_idx=0, shift reg=0.
- State: shift reg sr, rep counter (0..SCALE-1), bit_idx (0..GLYPH_W-1), active flag, holding register hold with hold_valid.
- Invariant: hold_valid implies active.
- in_ready = !hold_valid && !flush. This is combinational and has no path from pix_en.
- Accepting a row:
  - active=0: in_row loads directly into sr; rep=0, bit_idx=0; active=1 next cycle.
  - active=1: in_row goes to hold; hold_valid=1.
- pix_en=1 with active=1:
  - pix_out<=sr[GLYPH_W-1], pix_valid<=1, sub_phase<=rep.
  - If rep<SCALE-1: rep++.
  - Else: rep=0, sr shifts left by 1, bit_idx++.
- Row end is pix_en && rep==SCALE-1 && bit_idx==GLYPH_W-1. At row end:
  - hold_valid=1: sr<=hold, hold_valid<=0, counters 0, active stays 1. Seamless.
  - Else, row accepted this same cycle: in_row loads into sr. Seamless.
  - Else: active<=0.
- pix_en=1 with active=0: pix_out<=0, pix_valid<=0, sub_phase<=0, underrun<=1.
- underrun is 0 on every other cycle.
- pix_en=0: outputs hold their values (underrun returns to 0); internal state unchanged apart from accepts.
- Latency:
  - Row accepted at edge t while idle: first pixel appears at the first pix_en edge after t, at the earliest t+1.
  - One output pixel per pix_en, total GLYPH_W*SCALE pixels per row.
- flush=1 (synchronous, wins over everything):
  - active=0, hold_valid=0, rep=0, bit_idx=0, pix_valid<=0, pix_out<=0, underrun<=0.
  - No row is accepted that cycle.
- rst_n asserted mid-row: immediate return to reset values; partial row and hold contents are discarded.
- Width rule: counters sized $clog2 of their range with a minimum of 1 bit. SCALE=1 degenerates to a plain serializer (rep is always 0).

Decomposition:
- No shared typedefs needed.
- Add the glyph row width constant (GLYPH_W=8) and scale (3) to the existing VGA constants package, so the divide-by-3 address side and this expander agree.
- One natural sub-module: glyph_rep_ctr. It holds the rep and bit_idx counters and produces the row_end and bit_adv strobes.

Test Plan:
- Single row 8'b1010_0001, pix_en=1 continuously -> pix_out = 111 000 111 000 000 000 000 111 (24 pixels, pix_valid=1); sub_phase cycles 0,1,2; then underrun pulses each cycle, pix_valid=0.
- Rows 8'hFF then 8'h00, second row offered during the first -> 24 ones then 24 zeros with no gap; in_ready=0 while hold is full and returns to 1 at the row-1 end edge.
- Gapped pix_en (1 of every 2 cycles) with row 8'h80 -> 3 ones then 21 zeros, each pixel held across its idle cycle; no underrun.
- flush asserted at pixel 10 of row 8'hF0 with in_valid=1 -> in_ready=0 that cycle; next cycle active=0, pix_valid=0; a new row 8'h01 then starts at rep=0, bit_idx=0 (21 zeros, then 3 ones).
- rst_n pulled low mid-row with hold full -> all outputs 0 asynchronously; after release, in_ready=1 and the first pix_en gives underrun=1.
- SCALE=1, GLYPH_W=4 build, row 4'b1001 -> pix_out 1,0,0,1, back-to-back with the next row 4'b0110.
